// File: rtl/inst_prefetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue_pkg
//
// Shared constants and types for the instruction prefetch queue:
//   INST_NOP          - instruction presented to decode when nothing is valid
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   state_e           - prefetch control states (S_IDLE / S_RUN / S_DRAIN)
// ---------------------------------------------------------------------------
package inst_prefetch_queue_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Small single-clock FIFO used twice by the prefetch queue (PC tags and
// {pc, inst} data).  DEPTH must be a power of two so the pointers wrap
// naturally.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear_i    - drop all entries (wins over push/pop)
//   push_i     - write data_i at the tail
//   pop_i      - remove the head entry
//   data_i     - write data
//   head_o     - current head entry (meaningless when count_o == 0)
//   count_o    - number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo
    import inst_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is only legal when the head leaves in the
    // same cycle; a pop from an empty FIFO is ignored.
    always_comb begin
        doPush = push_i && ((count_q != CW'(DEPTH)) || pop_i);
        doPop  = pop_i && (count_q != '0);
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset: the count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (doPush && !clear_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue
//
// Prefetch stage in front of InstFetch/InstDecode.  Issues in-order word
// fetches, buffers returned words with their PCs and hands one {pc, inst}
// per cycle to decode.  A redirect flushes the queue and marks every
// in-flight response as stale so it is thrown away when it returns.
//
// Optional feature (macro PREFETCH_BYPASS_EN): when the data FIFO is empty
// and nothing is being dropped, a returning word is shown on IF_* in the
// same cycle instead of one cycle later.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   hold                - decode stall, head entry stays
//   jmp_vld, jmp_addr   - redirect request and word-aligned target
//   req_vld, req_addr   - fetch request to instruction memory
//   req_rdy             - memory accepts the request
//   resp_vld, resp_data - in-order fetch response
//   IF_vld, IF_pc, IF_inst - head entry for decode (NOP when not valid)
// ---------------------------------------------------------------------------
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        jmp_vld,
    input  logic [31:0] jmp_addr,
    output logic        req_vld,
    output logic [31:0] req_addr,
    input  logic        req_rdy,
    input  logic        resp_vld,
    input  logic [31:0] resp_data,
    output logic        IF_vld,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    localparam int CW = $clog2(DEPTH+1);

    state_e        state_q;
    state_e        state_d;
    logic [31:0]   fetchPc_q;
    logic [31:0]   fetchPc_d;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] dropCnt_q;
    logic [CW-1:0] dropCnt_d;

    logic [31:0]   tagHead;
    logic [CW-1:0] tagCount;
    logic [63:0]   dataHead;
    logic [CW-1:0] dataCount;

    logic [CW-1:0] inFlight;
    logic [CW:0]   used;
    logic          hasCredit;
    logic          fire;
    logic          respKeep;
    logic          bypassHit;
    logic          dataPush;
    logic          dataPop;

    // Credit counts FIFO slots not yet promised to a live response.  Stale
    // responses do not need a slot.  The tag FIFO also caps the number of
    // requests in flight at DEPTH, which matters while stale responses are
    // still on their way back after a redirect.
    always_comb begin
        inFlight  = outstanding_q - dropCnt_q;
        used      = {1'b0, dataCount} + {1'b0, inFlight};
        hasCredit = used < (CW+1)'(DEPTH);
        req_vld   = (state_q != S_IDLE) && hasCredit &&
                    (tagCount != CW'(DEPTH)) && !jmp_vld;
        req_addr  = fetchPc_q;
        fire      = req_vld && req_rdy;
    end

    // A response is kept only when it is not stale and no redirect is
    // flushing the queue in the same cycle.
    always_comb begin
        respKeep = resp_vld && (dropCnt_q == '0) && !jmp_vld;
`ifdef PREFETCH_BYPASS_EN
        bypassHit = respKeep && (dataCount == '0);
`else
        bypassHit = 1'b0;
`endif
        dataPush = respKeep && !(bypassHit && !hold);
        dataPop  = (dataCount != '0) && !hold && !jmp_vld;
    end

    // PC tags, one per accepted request, popped by every response including
    // the dropped ones, so a redirect never clears this FIFO.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tagFifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .push_i  (fire),
        .pop_i   (resp_vld),
        .data_i  (fetchPc_q),
        .head_o  (tagHead),
        .count_o (tagCount)
    );

    // {pc, inst} entries waiting for decode; flushed on redirect.
    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_dataFifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (jmp_vld),
        .push_i  (dataPush),
        .pop_i   (dataPop),
        .data_i  ({tagHead, resp_data}),
        .head_o  (dataHead),
        .count_o (dataCount)
    );

    // Decode-facing outputs: bypassed response, else FIFO head, else NOP.
    always_comb begin
        IF_vld  = (dataCount != '0) || bypassHit;
        IF_pc   = 32'h0000_0000;
        IF_inst = INST_NOP;
        if (bypassHit) begin
            IF_pc   = tagHead;
            IF_inst = resp_data;
        end else if (dataCount != '0) begin
            IF_pc   = dataHead[63:32];
            IF_inst = dataHead[31:0];
        end
    end

    // Next-state logic.  A redirect overrides issue and recomputes the
    // number of stale responses from what is still in flight after this
    // cycle's response, which is itself discarded.
    always_comb begin
        state_d       = state_q;
        fetchPc_d     = fetchPc_q;
        outstanding_d = outstanding_q + CW'(fire) - CW'(resp_vld);
        dropCnt_d     = dropCnt_q;

        if (jmp_vld) begin
            fetchPc_d = jmp_addr;
            dropCnt_d = outstanding_q - CW'(resp_vld);
        end else begin
            if (fire) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (resp_vld && (dropCnt_q != '0)) begin
                dropCnt_d = dropCnt_q - CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                if (jmp_vld) begin
                    state_d = (outstanding_d != '0) ? S_DRAIN : S_RUN;
                end else if ((state_q == S_DRAIN) && (dropCnt_d == '0)) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetchPc_q     <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetchPc_q     <= fetchPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

`ifndef SYNTHESIS
    // Credit accounting should make a push into a full data FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((dataCount == CW'(DEPTH)) && dataPush && !dataPop))
                else $error("inst_prefetch_queue: push into full data FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_queue
//
// Directed bench for inst_prefetch_queue with a simple in-order memory whose
// latency can be changed between scenarios.  Instruction words are a fixed
// function of their address so every IF_inst can be predicted.
// ---------------------------------------------------------------------------
module tb_inst_prefetch_queue;
    import inst_prefetch_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic        req_vld;
    logic [31:0] req_addr;
    logic        req_rdy;
    logic        resp_vld;
    logic [31:0] resp_data;
    logic        IF_vld;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t memQ[$];
    int      memLat;
    int      cyc;
    int      checks;
    int      failures;

    inst_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .jmp_vld   (jmp_vld),
        .jmp_addr  (jmp_addr),
        .req_vld   (req_vld),
        .req_addr  (req_addr),
        .req_rdy   (req_rdy),
        .resp_vld  (resp_vld),
        .resp_data (resp_data),
        .IF_vld    (IF_vld),
        .IF_pc     (IF_pc),
        .IF_inst   (IF_inst)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                failures++;
                $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            end
    endtask

    task automatic applyStimulus(input logic h, input logic j,
                                 input logic [31:0] ja, input logic r);
        hold     = h;
        jmp_vld  = j;
        jmp_addr = ja;
        req_rdy  = r;
    endtask

    // One clock cycle: record an accepted request, cross the edge, then
    // drive the memory response for the new cycle.  A redirect is a
    // one-cycle pulse and is dropped at the following negedge.
    task automatic tick();
        logic        accepted;
        logic [31:0] accAddr;
        #1;
        accepted = req_vld && req_rdy;
        accAddr  = req_addr;
        @(posedge clk);
        cyc++;
        if (accepted) begin
            memQ.push_back('{addr: accAddr, due: cyc + memLat - 1});
        end
        @(negedge clk);
        jmp_vld   = 1'b0;
        resp_vld  = 1'b0;
        resp_data = 32'h0;
        if ((memQ.size() > 0) && (memQ[0].due <= cyc)) begin
            resp_vld  = 1'b1;
            resp_data = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end
        #1;
    endtask

    // Wait (bounded) for the next valid head, check it, and let it be
    // consumed (hold must be low).
    task automatic expectNextIf(input string tag, input logic [31:0] expPc);
        bit found;
        found = 1'b0;
        for (int i = 0; (i < 12) && !found; i++) begin
            if (IF_vld === 1'b1) begin
                found = 1'b1;
                checkOutput({tag, "_pc"}, IF_pc, expPc);
                checkOutput({tag, "_inst"}, IF_inst, memWord(expPc));
            end
            tick();
        end
        checkOutput({tag, "_found"}, {31'b0, found}, 32'd1);
    endtask

    task automatic doReset(input int lat);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        resp_vld  = 1'b0;
        resp_data = 32'h0;
        memQ.delete();
        memLat = lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_vld"}, {31'b0, req_vld}, 32'd0);
        checkOutput({tag, "_IF_vld"}, {31'b0, IF_vld}, 32'd0);
        checkOutput({tag, "_IF_pc"}, IF_pc, 32'h0);
        checkOutput({tag, "_IF_inst"}, IF_inst, INST_NOP);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        memLat    = 1;
        rst       = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        resp_vld  = 1'b0;
        resp_data = 32'h0;

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");

        // Streaming, latency 1: one idle cycle, then 0,4,8,...
        doReset(1);
        checkOutput("idle_req_vld", {31'b0, req_vld}, 32'd0);
        tick();
        checkOutput("first_req_vld", {31'b0, req_vld}, 32'd1);
        checkOutput("first_req_addr", req_addr, 32'h0);
        tick();
        checkOutput("second_req_addr", req_addr, 32'h4);
`ifdef PREFETCH_BYPASS_EN
        checkOutput("bypass_IF_vld", {31'b0, IF_vld}, 32'd1);
        checkOutput("bypass_IF_pc", IF_pc, 32'h0);
        tick();
`else
        checkOutput("lat1_IF_vld_early", {31'b0, IF_vld}, 32'd0);
        tick();
        checkOutput("third_req_addr", req_addr, 32'h8);
        checkOutput("lat1_IF_vld", {31'b0, IF_vld}, 32'd1);
        checkOutput("lat1_IF_pc", IF_pc, 32'h0);
        tick();
`endif
        expectNextIf("stream4", 32'h4);
        expectNextIf("stream8", 32'h8);
        checkOutput("outstanding_cap", {31'b0, (memQ.size() + int'(resp_vld)) <= 4}, 32'd1);

        // Redirect together with a response and a pop.
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
        tick();
        checkOutput("jmp_IF_vld", {31'b0, IF_vld}, 32'd0);
        checkOutput("jmp_IF_inst", IF_inst, INST_NOP);
        checkOutput("jmp_req_addr", req_addr, 32'h100);
        checkOutput("jmp_state", 32'(dut.state_q), 32'(S_RUN));
        expectNextIf("jmp100", 32'h100);
        expectNextIf("jmp104", 32'h104);

        // Fetch address wrap.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        checkOutput("wrap_req_addr0", req_addr, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_req_addr1", req_addr, 32'h0);
        expectNextIf("wrapTop", 32'hFFFF_FFFC);
        expectNextIf("wrapZero", 32'h0);

        // Hold for many cycles: queue fills, issue stops, head stays at 0.
        doReset(1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (12) tick();
        checkOutput("hold_req_vld", {31'b0, req_vld}, 32'd0);
        checkOutput("hold_IF_vld", {31'b0, IF_vld}, 32'd1);
        checkOutput("hold_IF_pc", IF_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        expectNextIf("rel0", 32'h0);
        expectNextIf("rel4", 32'h4);
        expectNextIf("rel8", 32'h8);
        expectNextIf("rel12", 32'hC);
        expectNextIf("rel16", 32'h10);

        // Redirect while holding: the flush wins.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) tick();
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        tick();
        checkOutput("holdjmp_IF_vld", {31'b0, IF_vld}, 32'd0);
        checkOutput("holdjmp_req_addr", req_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        expectNextIf("holdjmp200", 32'h200);

        // Latency 3, redirect with three requests in flight.
        doReset(3);
        repeat (4) tick();
        checkOutput("drain_inflight", memQ.size() + int'(resp_vld), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
        tick();
        checkOutput("drain_state", 32'(dut.state_q), 32'(S_DRAIN));
        checkOutput("drain_IF_vld", {31'b0, IF_vld}, 32'd0);
        checkOutput("drain_req_addr", req_addr, 32'h100);
        tick();
        tick();
        checkOutput("drain_done_state", 32'(dut.state_q), 32'(S_RUN));
        expectNextIf("drain100", 32'h100);
        expectNextIf("drain104", 32'h104);

        // Reset in the middle of a latency-2 stream.
        doReset(2);
        repeat (6) tick();
        checkOutput("midrst_inflight", memQ.size() + int'(resp_vld), 32'd2);
        checkOutput("midrst_IF_vld_before", {31'b0, IF_vld}, 32'd1);
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        doReset(1);
        checkOutput("midrst_idle_req_vld", {31'b0, req_vld}, 32'd0);
        tick();
        checkOutput("midrst_req_addr", req_addr, 32'h0);
        expectNextIf("midrst0", 32'h0);

        $display("[TB] directed sequence complete at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
